// File: rtl/ycell_cfg_pkg.sv
// rtl/ycell_cfg_pkg.sv - shared constants for the ycell column configuration loader
//
// Purpose: state encodings, the default cell width and a counter-width helper
//          used by ycell_cfg_loader and ycell_cfg_shifter.
// Ports:   none (package).
package ycell_cfg_pkg;

  // Configuration bits held by one ycell.
  localparam int CELL_BITS_DEF = 3;

  // Loader FSM encodings.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_FETCH  = 3'd2;
  localparam logic [2:0] ST_SETUP  = 3'd3;
  localparam logic [2:0] ST_PULSE  = 3'd4;
  localparam logic [2:0] ST_HOLD   = 3'd5;
  localparam logic [2:0] ST_FINISH = 3'd6;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ycell_cfg_shifter.sv
// rtl/ycell_cfg_shifter.sv - parallel-load, MSB-first serial shift register
//
// Purpose: one W-bit register that can be loaded in parallel or shifted left
//          by one position, taking shift_in into the LSB. Used both as the
//          transmit serializer and the readback deserializer.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   load, load_data       parallel load (has priority over shift)
//   shift, shift_in       shift left by one, shift_in enters at bit 0
//   q                     register contents; q[W-1] is the next serial bit
module ycell_cfg_shifter
  import ycell_cfg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic         shift_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[W-2:0], shift_in};
    end
  end

endmodule

// File: rtl/ycell_cfg_loader.sv
// rtl/ycell_cfg_loader.sv - configuration chain sequencer for one ycell column
//
// Purpose: clears the column, serializes host words MSB-first onto cbitin with
//          a three-phase setup / confclk pulse / hold strobe per bit, and
//          collects the bits leaving the chain bottom into readback words.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   start, busy, done             load request, load in progress, completion pulse
//   in_valid, in_ready, in_data   host configuration words (MSB shifted first)
//   out_valid, out_ready, out_data readback words (first bit out in MSB)
//   cell_reset, confclk, cbitin   registered control pins of the ycell array
//   cbitout                       serial output from the bottom ycell
module ycell_cfg_loader
  import ycell_cfg_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int CELL_BITS  = CELL_BITS_DEF,
  parameter int DATA_W     = 8,
  parameter int CLR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              cell_reset,
  output logic              confclk,
  output logic              cbitin,
  input  logic              cbitout
);

  localparam int CHAIN_LEN = ROWS * CELL_BITS;
  localparam int CHAIN_CW  = cnt_w(CHAIN_LEN);
  localparam int WORD_CW   = cnt_w(DATA_W);
  localparam int RX_CW     = cnt_w(DATA_W + 1);
  localparam int CLR_CW    = cnt_w(CLR_CYCLES);

  localparam logic [CHAIN_CW-1:0] CHAIN_LAST = CHAIN_CW'(CHAIN_LEN - 1);
  localparam logic [WORD_CW-1:0]  WORD_LAST  = WORD_CW'(DATA_W - 1);
  localparam logic [RX_CW-1:0]    RX_LAST    = RX_CW'(DATA_W - 1);
  localparam logic [RX_CW-1:0]    RX_FULL    = RX_CW'(DATA_W);
  localparam logic [CLR_CW-1:0]   CLR_LAST   = CLR_CW'(CLR_CYCLES - 1);

  logic [2:0]          state;
  logic [CLR_CW-1:0]   clr_cnt;
  logic [CHAIN_CW-1:0] chain_cnt;
  logic [WORD_CW-1:0]  wbit_cnt;
  logic [RX_CW-1:0]    rx_cnt;

  logic [DATA_W-1:0]   tx_q;
  logic [DATA_W-1:0]   rx_q;
  logic                tx_load;
  logic                tx_shift;
  logic                rx_load;
  logic                rx_shift;
  logic                rx_stall;
  logic                unused_tx;

  // The sample taken in this SETUP would complete a readback word while the
  // previous one is still waiting for the consumer: hold off the strobe.
  assign rx_stall = (state == ST_SETUP) && (rx_cnt == RX_LAST) && out_valid && !out_ready;

  assign tx_load  = (state == ST_FETCH) && in_valid;
  // Shifting during PULSE leaves the next bit at the MSB by HOLD, while the
  // already-registered cbitin stays untouched through the strobe.
  assign tx_shift = (state == ST_PULSE);
  assign rx_load  = (state == ST_IDLE) && start;
  assign rx_shift = (state == ST_SETUP) && !rx_stall;

  // Only the MSB of the transmit register is ever driven onto the chain.
  assign unused_tx = ^tx_q[DATA_W-2:0];

  ycell_cfg_shifter #(.W(DATA_W)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (tx_load),
    .load_data (in_data),
    .shift     (tx_shift),
    .shift_in  (1'b0),
    .q         (tx_q)
  );

  ycell_cfg_shifter #(.W(DATA_W)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .load      (rx_load),
    .load_data ({DATA_W{1'b0}}),
    .shift     (rx_shift),
    .shift_in  (cbitout),
    .q         (rx_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      cell_reset <= 1'b1;
      confclk    <= 1'b0;
      cbitin     <= 1'b0;
      clr_cnt    <= '0;
      chain_cnt  <= '0;
      wbit_cnt   <= '0;
      rx_cnt     <= '0;
    end else begin
      done <= 1'b0;
      // Consumer acceptance; any load of a new word below overrides this.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_CLEAR;
            busy       <= 1'b1;
            cell_reset <= 1'b1;
            clr_cnt    <= '0;
            chain_cnt  <= '0;
            wbit_cnt   <= '0;
            rx_cnt     <= '0;
          end
        end

        ST_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            cell_reset <= 1'b0;
            in_ready   <= 1'b1;
            state      <= ST_FETCH;
          end else begin
            clr_cnt <= clr_cnt + CLR_CW'(1);
          end
        end

        ST_FETCH: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            cbitin   <= in_data[DATA_W-1];
            wbit_cnt <= '0;
            state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (!rx_stall) begin
            confclk <= 1'b1;
            state   <= ST_PULSE;
            if (rx_cnt == RX_LAST) begin
              out_data  <= {rx_q[DATA_W-2:0], cbitout};
              out_valid <= 1'b1;
              rx_cnt    <= '0;
            end else begin
              rx_cnt <= rx_cnt + RX_CW'(1);
            end
          end
        end

        ST_PULSE: begin
          confclk <= 1'b0;
          state   <= ST_HOLD;
        end

        ST_HOLD: begin
          if (chain_cnt == CHAIN_LAST) begin
            state <= ST_FINISH;
          end else begin
            chain_cnt <= chain_cnt + CHAIN_CW'(1);
            if (wbit_cnt == WORD_LAST) begin
              in_ready <= 1'b1;
              state    <= ST_FETCH;
            end else begin
              wbit_cnt <= wbit_cnt + WORD_CW'(1);
              cbitin   <= tx_q[DATA_W-1];
              state    <= ST_SETUP;
            end
          end
        end

        ST_FINISH: begin
          if (rx_cnt != '0) begin
            // Partial trailing word: left-align the collected bits, zero below.
            if (!out_valid || out_ready) begin
              out_data  <= rx_q << (RX_FULL - rx_cnt);
              out_valid <= 1'b1;
              rx_cnt    <= '0;
            end
          end else if (!out_valid || out_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ycell_cfg_loader.sv
// tb/tb_ycell_cfg_loader.sv - self-checking bench for ycell_cfg_loader with ycell column models
module tb_ycell_cfg_loader;

  logic clk = 1'b0;
  logic reset, start, in_valid, out_ready, sel;
  logic [7:0] in_data;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  logic start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  logic a_busy, a_done, a_in_ready, a_out_valid, a_cell_reset, a_confclk, a_cbitin, a_cbitout;
  logic b_busy, b_done, b_in_ready, b_out_valid, b_cell_reset, b_confclk, b_cbitin, b_cbitout;
  logic [7:0] a_out_data, b_out_data;

  ycell_cfg_loader #(.ROWS(8), .CELL_BITS(3), .DATA_W(8), .CLR_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(a_busy), .done(a_done),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .cell_reset(a_cell_reset), .confclk(a_confclk), .cbitin(a_cbitin), .cbitout(a_cbitout)
  );

  ycell_cfg_loader #(.ROWS(3), .CELL_BITS(3), .DATA_W(8), .CLR_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(b_busy), .done(b_done),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .cell_reset(b_cell_reset), .confclk(b_confclk), .cbitin(b_cbitin), .cbitout(b_cbitout)
  );

  // Column models: the chain shifts on confclk unless the cells are held in reset.
  logic [23:0] chain_a = '0;
  logic [8:0]  chain_b = '0;
  always @(posedge a_confclk) if (!a_cell_reset) chain_a <= {chain_a[22:0], a_cbitin};
  always @(posedge b_confclk) if (!b_cell_reset) chain_b <= {chain_b[7:0], b_cbitin};
  assign a_cbitout = chain_a[23];
  assign b_cbitout = chain_b[8];

  logic busy_m, done_m, in_ready_m, out_valid_m, cell_reset_m, confclk_m, cbitin_m;
  logic [7:0] out_data_m;
  assign busy_m       = sel ? b_busy       : a_busy;
  assign done_m       = sel ? b_done       : a_done;
  assign in_ready_m   = sel ? b_in_ready   : a_in_ready;
  assign out_valid_m  = sel ? b_out_valid  : a_out_valid;
  assign cell_reset_m = sel ? b_cell_reset : a_cell_reset;
  assign confclk_m    = sel ? b_confclk    : a_confclk;
  assign cbitin_m     = sel ? b_cbitin     : a_cbitin;
  assign out_data_m   = sel ? b_out_data   : a_out_data;

  // Monitor on the falling edge: strobes, host handshakes, accepted readback words.
  int pulses = 0;
  int hs = 0;
  logic conf_prev = 1'b0;
  bit obs_bits[$];
  logic [7:0] obs_rb[$];
  always @(negedge clk) begin
    if (confclk_m && !conf_prev) begin
      pulses++;
      obs_bits.push_back(cbitin_m);
    end
    conf_prev = confclk_m;
    if (in_valid && in_ready_m) hs++;
    if (out_valid_m && out_ready) obs_rb.push_back(out_data_m);
  end

  // Reference chain contents per column, front = bottom cell (next bit out).
  bit ref_a[$];
  bit ref_b[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic s, input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input int gap, input int rdy,
                         input int exp_cyc, input bit stall, input int abort_n);
    logic [7:0] wv[3];
    bit exp_bits[$];
    bit rb_bits[$];
    bit rq[$];
    logic [7:0] exp_rb[$];
    logic [7:0] w;
    logic [31:0] ev, ov, ecv, gotv;
    int clen, nw, nbits, widx, cnt, p0, h0, r0, b0, stall_left, p_mid;
    bit fin, aborted;

    sel = s;
    wv[0] = w0; wv[1] = w1; wv[2] = w2;
    clen  = s ? 9 : 24;
    nw    = s ? 2 : 3;
    nbits = (abort_n > 0) ? abort_n : clen;

    // Reference: the chain is a FIFO of clen bits; each strobe pops the bottom
    // bit into readback and pushes the next host bit (MSB first) at the top.
    for (int i = 0; i < nbits; i++) begin
      w = wv[i / 8];
      exp_bits.push_back(w[7 - (i % 8)]);
    end
    rq = s ? ref_b : ref_a;
    for (int i = 0; i < nbits; i++) begin
      rb_bits.push_back(rq.pop_front());
      rq.push_back(exp_bits[i]);
    end
    if (s) ref_b = rq; else ref_a = rq;
    for (int i = 0; i < rb_bits.size(); i += 8) begin
      w = 8'h00;
      for (int j = 0; j < 8; j++) if (i + j < rb_bits.size()) w[7 - j] = rb_bits[i + j];
      exp_rb.push_back(w);
    end

    p0 = pulses; h0 = hs; r0 = obs_rb.size(); b0 = obs_bits.size();
    widx = 0; cnt = 0; fin = 0; aborted = 0; stall_left = -1; p_mid = 0;
    start = 1'b1;
    while (!fin && cnt < 4000) begin
      if (widx < nw) begin
        in_valid = ($urandom_range(99) >= gap);
        in_data  = in_valid ? wv[widx] : 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
      if (in_valid && in_ready_m && widx < nw) widx++;
      if (stall && stall_left < 0 && out_valid_m) stall_left = 80;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        if (stall_left == 40) p_mid = pulses;
        if (stall_left == 1) begin
          check("stall_pulses", pulses - p0, 15);
          check("stall_quiet", pulses, p_mid);
          check("stall_busy", busy_m, 1);
        end
        stall_left--;
      end else begin
        out_ready = ($urandom_range(99) < rdy);
      end

      @(posedge clk); #1;
      cnt++;
      start = (cnt == 20);
      if (cnt == 1) check("busy_after_start", busy_m, 1);
      if (done_m) begin
        fin = 1;
        check("busy_at_done", busy_m, 0);
        if (exp_cyc > 0) check("done_cycle", cnt, exp_cyc);
      end else if (abort_n > 0 && pulses - p0 == abort_n) begin
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_confclk", confclk_m, 0);
        check("abort_cell_reset", cell_reset_m, 1);
        check("abort_busy", busy_m, 0);
        check("abort_in_ready", in_ready_m, 0);
        check("abort_out_valid", out_valid_m, 0);
        reset = 1'b0;
        fin = 1; aborted = 1;
      end
    end
    start = 1'b0;
    if (!fin) check("load_timeout", 0, 1);
    in_valid = 1'b0;

    @(posedge clk); #1;
    if (!aborted) check("done_pulse", done_m, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("idle_after_load", busy_m, 0);
    end

    check("pulse_count", pulses - p0, nbits);
    ev = '0; ov = '0;
    for (int i = 0; i < nbits; i++) ev = {ev[30:0], exp_bits[i]};
    for (int i = 0; i < pulses - p0 && i < 32; i++) ov = {ov[30:0], obs_bits[b0 + i]};
    check("cbitin_seq", ov, ev);
    ecv = '0;
    for (int i = 0; i < clen; i++) ecv[clen - 1 - i] = rq[i];
    gotv = s ? 32'(chain_b) : 32'(chain_a);
    check("chain_contents", gotv, ecv);
    if (!aborted) begin
      check("handshakes", hs - h0, nw);
      check("rb_count", obs_rb.size() - r0, exp_rb.size());
      for (int i = 0; i < exp_rb.size(); i++) begin
        gotv = (r0 + i < obs_rb.size()) ? 32'(obs_rb[r0 + i]) : 32'hDEAD_BEEF;
        check($sformatf("rb_word%0d", i), gotv, 32'(exp_rb[i]));
      end
    end
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    for (int i = 0; i < 24; i++) ref_a.push_back(1'b0);
    for (int i = 0; i < 9; i++) ref_b.push_back(1'b0);

    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_cell_reset", {a_cell_reset, b_cell_reset}, 2'b11);
      check("rst_confclk", {a_confclk, b_confclk}, 2'b00);
      check("rst_busy", {a_busy, b_busy}, 2'b00);
      check("rst_out_valid", {a_out_valid, b_out_valid}, 2'b00);
      check("rst_misc", {a_done, b_done, a_in_ready, b_in_ready, a_cbitin, b_cbitin}, 6'b0);
      check("rst_out_data", {a_out_data, b_out_data}, 16'h0000);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    do_load(1'b0, 8'hA5, 8'h3C, 8'hFF, 0, 100, 81, 1'b0, 0);
    do_load(1'b0, 8'hA5, 8'h3C, 8'hFF, 0, 100, 81, 1'b0, 0);
    do_load(1'b1, 8'hFF, 8'h80, 8'h00, 0, 100, 0, 1'b0, 0);
    do_load(1'b1, 8'hFF, 8'h80, 8'h00, 30, 70, 0, 1'b0, 0);
    do_load(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 0, 100, 0, 1'b1, 0);
    do_load(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 0, 100, 0, 1'b0, 10);
    do_load(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 30, 60, 0, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      do_load(1'($urandom_range(1)), 8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(50)), 30 + int'($urandom_range(70)), 0, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
